addsub_acc_pipe: RTL and testbench
==================================

Name: addsub_acc_pipe

Overview:
- Registered, parametrised adder/subtractor with valid/ready handshake on input and output.
- Four operations: add, subtract, accumulate-add and accumulate-subtract, using an internal accumulator.
- Produces carry/borrow and signed-overflow flags as registered outputs, replacing simulation-only overflow reporting.
- Sits between the operand source and the result consumer in the datapath, with back-pressure support.

Parameters:
- WIDTH, 8, operand/result/accumulator width in bits (≥2).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- op  in  2  00 ADD (a+b), 01 SUB (a-b), 10 ACC_ADD (acc+b), 11 ACC_SUB (acc-b)
- a  in  WIDTH  first operand; ignored for ACC ops
- b  in  WIDTH  second operand
- acc_clr  in  1  synchronous accumulator clear; independent of in_valid
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  sum/difference
- c_out  out  1  carry out of the WIDTH-bit adder; for SUB ops 1 = no borrow
- ovf  out  1  signed two's-complement overflow of this result
- acc  out  WIDTH  current accumulator value

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, result=0, c_out=0, ovf=0, acc=0. rst overrides every other input, including a handshake in progress.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; single output register, no skid).
  - A beat is accepted when in_valid && in_ready.
  - Latency is 1 cycle: an accepted beat's result appears with out_valid=1 on the next cycle.
  - result/c_out/ovf hold stable while out_valid && !out_ready.
  - out_valid clears on out_ready with no new accept.
  - Full throughput when out_ready is held high.
- Arithmetic:
  - X = a for ADD/SUB; X = acc_eff for ACC ops.
  - acc_eff = 0 if acc_clr is high in the same cycle, otherwise acc.
  - Y = b for add ops, ~b for sub ops; cin = 0 for add ops, 1 for sub ops.
  - {c_out, r} = X + Y + cin, computed at WIDTH+1 bits.
  - ovf = (X[MSB] == Y[MSB]) && (r[MSB] != X[MSB]).
  - Subtracting the most-negative value is therefore flagged correctly: 0 - 0x80 gives ovf=1.
- Accumulator:
  - On an accepted ACC op, acc <= stored result, which is the saturated value when saturation is enabled.
  - ADD/SUB never modify acc.
  - acc_clr without an accepted ACC op: acc <= 0.
  - acc_clr with an accepted ACC op: the op uses 0 as its acc operand and acc <= that op's result.
  - acc_clr with an accepted ADD/SUB: acc <= 0 and the result is unaffected.
  - The acc port reflects the register, so an update is visible one cycle after accept.
- Wrap-around: without saturation, result is r modulo 2^WIDTH; ovf and c_out are still reported.
- Stalls: if out_valid && !out_ready, no beat is accepted and acc does not change, except through acc_clr.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN.
- Defined: when ovf=1, the stored result is clamped to the signed limit. Positive overflow (X[MSB]=0) gives 0x7F..F; negative overflow gives 0x80..0. The accumulator stores the clamped value. ovf still reports 1 and c_out remains the raw adder carry.
- Undefined: wrap-around behaviour as above; there is no clamp logic.

Decomposition:
- Package addsub_pkg:
  - op encoding constants OP_ADD=2'b00, OP_SUB=2'b01, OP_ACC_ADD=2'b10, OP_ACC_SUB=2'b11.
  - Helper functions is_sub(op) = op[0] and is_acc(op) = op[1].
- Sub-module addsub_core: purely combinational; X, b, sub → r, c_out, ovf, plus the saturated r under the macro.
- Top level holds the handshake, output register and accumulator.

Test Plan (WIDTH=8):
- Reset, then ADD a=0x7F b=0x01 → next cycle out_valid=1, result=0x80, ovf=1, c_out=0. With ADDSUB_SATURATE_EN: result=0x7F.
- SUB a=0x00 b=0x80 → result=0x80, ovf=1, c_out=0. SUB a=0x05 b=0x03 → result=0x02, c_out=1, ovf=0.
- acc_clr, then ACC_ADD b=0x10 three times with out_ready=1 → results 0x10, 0x20, 0x30 on consecutive cycles; acc=0x30. Then ACC_SUB b=0x40 → result=0xF0, ovf=0, c_out=0.
- Back-pressure: out_ready=0 with a result pending → in_ready=0, result held for 5 cycles, ACC beat not accepted and acc unchanged. out_ready=1 → accept resumes with no beat lost or duplicated.
- acc=0x30 with acc_clr and ACC_ADD b=0x07 in the same cycle → result=0x07, acc=0x07. acc_clr together with ADD a=1 b=1 → result=0x02, acc=0x00.
- rst asserted while out_valid=1 and out_ready=0 → next cycle out_valid=0, acc=0, result=0; first accept after release behaves normally.

Source files
------------

// File: rtl/addsub_pkg.sv
// addsub_pkg: op encoding and decode helpers shared by the add/sub pipeline.
package addsub_pkg;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_SUB     = 2'b01;
  localparam logic [1:0] OP_ACC_ADD = 2'b10;
  localparam logic [1:0] OP_ACC_SUB = 2'b11;

  // Low op bit selects subtraction (invert b, carry in 1).
  function automatic logic is_sub(input logic [1:0] op);
    return op[0];
  endfunction

  // High op bit selects the accumulator as the first operand.
  function automatic logic is_acc(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/addsub_core.sv
// addsub_core: combinational WIDTH-bit add/subtract with carry and signed
// overflow. With ADDSUB_SATURATE_EN defined, res is clamped to the signed
// limit on overflow; otherwise res is the wrapped sum.
module addsub_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] res,
  output logic             c_out,
  output logic             ovf
);

  logic [WIDTH-1:0] y;
  logic [WIDTH:0]   sum;

  // Two's-complement subtract as x + ~b + 1; overflow when like-signed
  // operands give a result of the other sign.
  always_comb begin
    y     = sub ? ~b : b;
    sum   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, sub};
    c_out = sum[WIDTH];
    ovf   = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
`ifdef ADDSUB_SATURATE_EN
    if (ovf)
      res = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      res = sum[WIDTH-1:0];
`else
    res   = sum[WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/addsub_acc_pipe.sv
// addsub_acc_pipe: one-stage registered add/sub/accumulate with valid/ready
// on both sides. Optional clamp on overflow via ADDSUB_SATURATE_EN (handled
// inside addsub_core; the accumulator stores whatever value is registered).
module addsub_acc_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             ovf,
  output logic [WIDTH-1:0] acc
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             accept;
  logic [WIDTH-1:0] acc_eff, x;
  logic [WIDTH-1:0] core_res;
  logic             core_c, core_ovf;

  // Single output register, no skid: accept only when it is empty or draining.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // A clear in the same cycle makes ACC ops start from zero.
  assign acc_eff = acc_clr ? '0 : acc_q;
  assign x       = is_acc(op) ? acc_eff : a;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .x     (x),
    .b     (b),
    .sub   (is_sub(op)),
    .res   (core_res),
    .c_out (core_c),
    .ovf   (core_ovf)
  );

  // Next-state: load on accept, drop valid when drained, acc follows ACC ops
  // or a standalone clear.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    c_out_d     = c_out_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = core_res;
      c_out_d     = core_c;
      ovf_d       = core_ovf;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept && is_acc(op))
      acc_d = core_res;
    else if (acc_clr)
      acc_d = '0;
  end

  // State registers with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_addsub_acc_pipe.sv
// tb_addsub_acc_pipe: directed literal checks plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_addsub_acc_pipe;

  localparam int W    = 8;
  localparam int MOD  = 1 << W;
  localparam int SMAX = (1 << (W-1)) - 1;
  localparam int SMIN = -(1 << (W-1));

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         acc_clr = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         c_out;
  logic         ovf;
  logic [W-1:0] acc;

  int total = 0;
  int bad   = 0;
  bit started = 0;

  // reference model state
  bit     m_valid = 0;
  int     m_res = 0;
  bit     m_c = 0;
  bit     m_ov = 0;
  int     m_acc = 0;

  addsub_acc_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .c_out(c_out), .ovf(ovf), .acc(acc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v > SMAX) ? v - MOD : v;
  endfunction

  // Plain integer arithmetic: unsigned result/carry, signed range test for ovf.
  task automatic calc(input logic [1:0] o, input int av, input int bv, input int accv,
                      input bit clr, output int res, output bit c, output bit ov);
    int x, sres, raw;
    x = o[1] ? (clr ? 0 : accv) : av;
    if (o[0]) begin
      raw  = x - bv;
      c    = (x >= bv);
      sres = to_signed(x) - to_signed(bv);
    end else begin
      raw  = x + bv;
      c    = (x + bv >= MOD);
      sres = to_signed(x) + to_signed(bv);
    end
    ov  = (sres > SMAX) || (sres < SMIN);
    res = ((raw % MOD) + MOD) % MOD;
`ifdef ADDSUB_SATURATE_EN
    if (ov) res = (sres > SMAX) ? SMAX : MOD + SMIN;
`endif
  endtask

  // Model update on each rising edge from the inputs held across it.
  always @(posedge clk) begin
    int r; bit c, ov;
    if (rst) begin
      m_valid <= 0; m_res <= 0; m_c <= 0; m_ov <= 0; m_acc <= 0;
      started <= 1;
    end else if (in_valid && (!m_valid || out_ready)) begin
      calc(op, int'(a), int'(b), m_acc, acc_clr, r, c, ov);
      m_valid <= 1; m_res <= r; m_c <= c; m_ov <= ov;
      if (op[1]) m_acc <= r;
      else if (acc_clr) m_acc <= 0;
    end else begin
      if (out_ready) m_valid <= 0;
      if (acc_clr) m_acc <= 0;
    end
  end

  // Every-cycle compare on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk("m_in_ready", int'(in_ready), int'(!m_valid || out_ready));
      chk("m_out_valid", int'(out_valid), int'(m_valid));
      chk("m_acc", int'(acc), m_acc);
      if (m_valid) begin
        chk("m_result", int'(result), m_res);
        chk("m_c_out", int'(c_out), int'(m_c));
        chk("m_ovf", int'(ovf), int'(m_ov));
      end
    end
  end

  task automatic beat(input bit v, input logic [1:0] o, input int av, input int bv,
                      input bit clr, input bit ordy);
    in_valid = v; op = o; a = av[W-1:0]; b = bv[W-1:0];
    acc_clr = clr; out_ready = ordy;
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_acc", int'(acc), 0);
    chk("rst_flags", int'({c_out, ovf}), 0);
    rst = 0;

    beat(1, 2'b00, 'h7F, 'h01, 0, 1);
    chk("add_valid", int'(out_valid), 1);
`ifdef ADDSUB_SATURATE_EN
    chk("add_result", int'(result), 'h7F);
`else
    chk("add_result", int'(result), 'h80);
`endif
    chk("add_ovf", int'(ovf), 1);
    chk("add_c", int'(c_out), 0);

    beat(1, 2'b01, 'h00, 'h80, 0, 1);
`ifdef ADDSUB_SATURATE_EN
    chk("sub_min_result", int'(result), 'h7F);
`else
    chk("sub_min_result", int'(result), 'h80);
`endif
    chk("sub_min_ovf", int'(ovf), 1);
    chk("sub_min_c", int'(c_out), 0);

    beat(1, 2'b01, 'h05, 'h03, 0, 1);
    chk("sub_result", int'(result), 'h02);
    chk("sub_c", int'(c_out), 1);
    chk("sub_ovf", int'(ovf), 0);

    beat(0, 2'b00, 0, 0, 1, 1);
    chk("clr_acc", int'(acc), 0);
    chk("clr_drain", int'(out_valid), 0);
    for (int i = 1; i <= 3; i++) begin
      beat(1, 2'b10, 0, 'h10, 0, 1);
      chk("accadd_result", int'(result), 'h10 * i);
      chk("accadd_valid", int'(out_valid), 1);
    end
    chk("accadd_acc", int'(acc), 'h30);
    beat(1, 2'b11, 0, 'h40, 0, 1);
    chk("accsub_result", int'(result), 'hF0);
    chk("accsub_flags", int'({c_out, ovf}), 0);
    chk("accsub_acc", int'(acc), 'hF0);

    // stall with an ACC beat waiting
    for (int i = 0; i < 5; i++) begin
      beat(1, 2'b10, 0, 'h01, 0, 0);
      chk("stall_ready", int'(in_ready), 0);
      chk("stall_result", int'(result), 'hF0);
      chk("stall_acc", int'(acc), 'hF0);
    end
    beat(1, 2'b10, 0, 'h01, 0, 1);
    chk("resume_result", int'(result), 'hF1);
    chk("resume_acc", int'(acc), 'hF1);
    beat(0, 2'b10, 0, 'h01, 0, 1);
    chk("resume_nodup", int'(acc), 'hF1);
    chk("resume_drain", int'(out_valid), 0);

    beat(1, 2'b10, 0, 'h30, 1, 1);
    chk("load_acc", int'(acc), 'h30);
    beat(1, 2'b10, 0, 'h07, 1, 1);
    chk("clr_accadd_result", int'(result), 'h07);
    chk("clr_accadd_acc", int'(acc), 'h07);
    beat(1, 2'b00, 1, 1, 1, 1);
    chk("clr_add_result", int'(result), 'h02);
    chk("clr_add_acc", int'(acc), 0);

    // reset during a stall
    beat(1, 2'b10, 0, 'h09, 0, 0);
    beat(1, 2'b00, 1, 2, 0, 0);
    chk("prerst_valid", int'(out_valid), 1);
    rst = 1;
    beat(1, 2'b00, 1, 2, 0, 0);
    chk("rst_stall_valid", int'(out_valid), 0);
    chk("rst_stall_acc", int'(acc), 0);
    chk("rst_stall_result", int'(result), 0);
    rst = 0;
    beat(1, 2'b00, 3, 4, 0, 1);
    chk("post_rst_result", int'(result), 7);
    chk("post_rst_valid", int'(out_valid), 1);

    // randomized traffic, checked by the model process
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      beat($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           int'($urandom_range(0, MOD-1)), int'($urandom_range(0, MOD-1)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7);
    end
    rst = 0;
    beat(0, 2'b00, 0, 0, 0, 1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
